// File: rtl/pulse_delay_meter.sv
// rtl/pulse_delay_meter.sv - multi-channel sent-to-receive edge delay meter
// Measures clk periods from a sent edge to the first receive edge per channel, with timeout and held result.
module pulse_delay_meter #(
    parameter int PERIODS_DIM = 16,
    parameter int CHANNELS    = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sent_signal,
    input  logic [CHANNELS-1:0]             recieved_signal,
    output logic [CHANNELS*PERIODS_DIM-1:0] delay_in_clk_periods,
    output logic [CHANNELS-1:0]             timeout_mask,
    output logic                            result_valid,
    input  logic                            result_ack,
    output logic                            overrun,
    output logic                            busy
);

    localparam int W = CHANNELS + 1;
    localparam logic [PERIODS_DIM-1:0] TIMEOUT_C = PERIODS_DIM'(TIMEOUT);

    typedef enum logic {IDLE, MEASURE} state_t;

    logic [W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [W-1:0] edge_q, edge_d;
    logic [1:0]   arm_q, arm_d;
    state_t       state_q, state_d;
    logic [PERIODS_DIM-1:0] count_q, count_d;
    logic [CHANNELS-1:0]    captured_q, captured_d;
    logic [CHANNELS-1:0][PERIODS_DIM-1:0] meas_q, meas_d;
    logic [CHANNELS-1:0][PERIODS_DIM-1:0] res_delay_q, res_delay_d;
    logic [CHANNELS-1:0]    res_mask_q, res_mask_d;
    logic valid_q, valid_d, overrun_q, overrun_d;
    logic                done;
    logic                sent_edge;
    logic [CHANNELS-1:0] recv_edge;

    // Edges are suppressed until the chain has refilled after reset, so a
    // level that was already high at release is not mistaken for an edge.
    always_comb begin
        sync1_d = {recieved_signal, sent_signal};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        edge_d  = (arm_q == 2'd3) ? (sync2_q & ~sync3_q) : '0;
    end

    assign sent_edge = edge_q[0];
    assign recv_edge = edge_q[W-1:1];

    // count_q holds the number of cycles elapsed since the sent-edge cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        captured_d  = captured_q;
        meas_d      = meas_q;
        res_delay_d = res_delay_q;
        res_mask_d  = res_mask_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (sent_edge) begin
                    state_d    = MEASURE;
                    count_d    = PERIODS_DIM'(1);
                    captured_d = '0;
                end
            end
            MEASURE: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (recv_edge[i] && !captured_q[i]) begin
                        captured_d[i] = 1'b1;
                        meas_d[i]     = count_q;
                    end
                end
                done = (&captured_d) || (count_q == TIMEOUT_C);
                if (done) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + PERIODS_DIM'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (result_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (done) begin
            for (int i = 0; i < CHANNELS; i++) begin
                res_delay_d[i] = captured_d[i] ? meas_d[i] : '0;
            end
            res_mask_d = ~captured_d;
            valid_d    = 1'b1;
            if (valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            edge_q      <= '0;
            arm_q       <= '0;
            state_q     <= IDLE;
            count_q     <= '0;
            captured_q  <= '0;
            meas_q      <= '0;
            res_delay_q <= '0;
            res_mask_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            edge_q      <= edge_d;
            arm_q       <= arm_d;
            state_q     <= state_d;
            count_q     <= count_d;
            captured_q  <= captured_d;
            meas_q      <= meas_d;
            res_delay_q <= res_delay_d;
            res_mask_q  <= res_mask_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign delay_in_clk_periods = res_delay_q;
    assign timeout_mask         = res_mask_q;
    assign result_valid         = valid_q;
    assign overrun              = overrun_q;
    assign busy                 = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_delay_meter.sv
// tb/tb_pulse_delay_meter.sv - self-checking bench for pulse_delay_meter
// Pulses are scheduled per cycle relative to the sent rise; expectations come from the delay rules.
module tb_pulse_delay_meter;

    localparam int P  = 16;
    localparam int CH = 4;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sent_signal = 1'b0;
    logic [CH-1:0]     recieved_signal = '0;
    logic              result_ack = 1'b0;
    logic [CH*P-1:0]   delay_in_clk_periods;
    logic [CH-1:0]     timeout_mask;
    logic              result_valid;
    logic              overrun;
    logic              busy;

    pulse_delay_meter #(.PERIODS_DIM(P), .CHANNELS(CH), .TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sent_signal          (sent_signal),
        .recieved_signal      (recieved_signal),
        .delay_in_clk_periods (delay_in_clk_periods),
        .timeout_mask         (timeout_mask),
        .result_valid         (result_valid),
        .result_ack           (result_ack),
        .overrun              (overrun),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int off[CH];
    bit second0, resend, ack_same;
    bit m_valid, m_overrun;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_case(input int a, input int b, input int c, input int d);
        off[0] = a; off[1] = b; off[2] = c; off[3] = d;
        second0 = 0; resend = 0; ack_same = 0;
    endtask

    // Sent rises in iteration S; a receive rising in iteration S+k should report k.
    task automatic measure(input string name);
        int S;
        int last;
        int d_exp[CH];
        logic [CH-1:0] mask_exp;
        int D;
        bit all;
        int busy_cnt;
        int fall;
        bit busy_prev;
        int ack_iter;
        bit rs;
        S = 2; last = S + TO + 20; D = 0; all = 1;
        busy_cnt = 0; fall = -1; busy_prev = 0;
        for (int i = 0; i < CH; i++) begin
            if (off[i] >= 1 && off[i] <= TO) begin
                d_exp[i] = off[i]; mask_exp[i] = 1'b0;
                if (off[i] > D) D = off[i];
            end else begin
                d_exp[i] = 0; mask_exp[i] = 1'b1; all = 0;
            end
        end
        if (!all) D = TO;
        rs = resend && (D >= 10);
        ack_iter = ack_same ? S + 3 + D : -1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy_prev && !busy && fall < 0) fall = c;
            busy_prev = busy;
            sent_signal = (c >= S && c < S + 3) || (rs && c >= S + 10 && c < S + 13);
            for (int i = 0; i < CH; i++) begin
                recieved_signal[i] = (off[i] >= 0 && c >= S + off[i] && c < S + off[i] + 3)
                    || (i == 0 && second0 && c >= S + off[0] + 6 && c < S + off[0] + 9);
            end
            result_ack = (c == ack_iter);
        end
        if (ack_same) m_overrun = 0;
        else if (m_valid) m_overrun = 1;
        m_valid = 1;
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s delay%0d", name, i), 64'(delay_in_clk_periods[i*P +: P]), 64'(d_exp[i]));
        end
        check({name, " mask"}, 64'(timeout_mask), 64'(mask_exp));
        check({name, " valid"}, 64'(result_valid), 64'(m_valid));
        check({name, " overrun"}, 64'(overrun), 64'(m_overrun));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(D));
        check({name, " busy_fall"}, 64'(fall), 64'(S + D + 4));
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        if (m_valid) begin
            m_valid = 0; m_overrun = 0;
        end
        check({name, " ack valid"}, 64'(result_valid), 64'(m_valid));
        check({name, " ack overrun"}, 64'(overrun), 64'(m_overrun));
    endtask

    initial begin
        bit busy_seen;
        int r;
        m_valid = 0; m_overrun = 0;
        repeat (3) @(negedge clk);
        check("rst delays", 64'(delay_in_clk_periods), 64'd0);
        check("rst mask", 64'(timeout_mask), 64'd0);
        check("rst valid", 64'(result_valid), 64'd0);
        check("rst overrun", 64'(overrun), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        set_case(20, 35, 50, 65);
        measure("basic");
        do_ack("basic");

        set_case(10, 30, -1, 40);
        measure("ch2_timeout");

        set_case(5, TO, 7, 9);
        second0 = 1;
        measure("edge_at_timeout_overrun");
        do_ack("overrun");

        set_case(0, 12, 14, 16);
        resend = 1;
        measure("same_cycle_and_resend");

        set_case(3, 4, 5, 6);
        ack_same = 1;
        measure("ack_at_completion");
        do_ack("after_ack_same");

        // Reset ten cycles into a measurement, with sent held high across release.
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            sent_signal = (c < 3);
        end
        @(negedge clk);
        check("busy before rst", 64'(busy), 64'd1);
        sent_signal = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("midrst delays", 64'(delay_in_clk_periods), 64'd0);
        check("midrst mask", 64'(timeout_mask), 64'd0);
        check("midrst valid", 64'(result_valid), 64'd0);
        check("midrst overrun", 64'(overrun), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        m_valid = 0; m_overrun = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("high sent after rst", 64'(busy_seen), 64'd0);
        sent_signal = 1'b0;
        repeat (4) @(negedge clk);
        set_case(8, 16, 24, 32);
        measure("after_rst");

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < CH; i++) begin
                r = $urandom_range(0, 99);
                if (r < 70) off[i] = $urandom_range(1, TO);
                else if (r < 85) off[i] = $urandom_range(TO + 1, TO + 15);
                else off[i] = -1;
            end
            second0  = 0;
            resend   = bit'($urandom_range(0, 1));
            ack_same = ($urandom_range(0, 3) == 0);
            measure($sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) do_ack($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
